muldiv_ctrl: RTL and testbench

- Sequencer for the multi-cycle multiplier and divider used by the execute stage.
- Accepts one MULT/MULTU/DIV/DIVU request from the E stage and latches its operands.
- Pulses the selected unit's start, stalls the pipeline until the unit reports ready, then presents the 64-bit {hi,lo} result for one cycle.
- Owns flush cancellation: a killed operation drains silently. A watchdog flags units that never complete.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencer.
//   op_e    : E-stage mul/div opcodes (bit 1 selects the divider, bit 0 = unsigned)
//   state_e : sequencer states
//   DIV0_LO : low word returned by the divide-by-zero fast path
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_DONE   = 2'b10,
    ST_CANCEL = 2'b11
  } state_e;

  // Fast-path divide-by-zero result is {src_a, DIV0_LO}.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the execute stage and the multi-cycle
// multiplier / divider.  Accepts one request, latches its operands, pulses
// the selected unit's start, stalls the pipeline until the unit is ready and
// presents the {hi,lo} result for one cycle.  Flushed operations drain
// silently; a watchdog flags a unit that never completes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, req_op        E-stage request and opcode (op_e encoding)
//   src_a, src_b             rs / rt operands
//   flush                    kill the in-flight E-stage instruction
//   muldiv_stall             hold F..E stages
//   result_valid, result     completed op and its {hi,lo} value
//   timeout                  sticky watchdog error
//   mul_start, mul_sign      multiplier control
//   div_start, div_sign      divider control
//   op_a, op_b               latched operands shared by both units
//   mul_ready, mul_result    multiplier completion pulse and value
//   div_ready, div_result    divider completion pulse and value
//
// Build option: define MULDIV_DIV0_FAST_EN to let DIV/DIVU with src_b == 0
// bypass the divider and complete directly with {src_a, 32'hFFFF_FFFF}.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        muldiv_stall,
  output logic        result_valid,
  output logic [63:0] result,
  output logic        timeout,
  output logic        mul_start,
  output logic        mul_sign,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        mul_ready,
  input  logic        div_ready,
  input  logic [63:0] mul_result,
  input  logic [63:0] div_result
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] wd_cnt;

  logic        accept;
  logic        sel_ready;
  logic [63:0] sel_result;
  logic        wd_expire;
  logic        in_flight;
  logic        div0_fast;

  assign accept     = req_valid & ~flush;
  // Only the unit that was started may complete the operation.
  assign sel_ready  = op_q[1] ? div_ready : mul_ready;
  assign sel_result = op_q[1] ? div_result : mul_result;
  // The cycle whose increment brings the count to MAX_LAT is the last one allowed.
  assign wd_expire  = (wd_cnt >= CNT_LAST);
  assign in_flight  = (state == ST_BUSY) || (state == ST_CANCEL);

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = req_op[1] & (src_b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  // Signs follow the latched opcode for as long as a unit is working on it.
  assign mul_sign = in_flight & (op_q == OP_MULT);
  assign div_sign = in_flight & (op_q == OP_DIV);

  // Stall and result_valid must react to flush/req_valid in the same cycle.
  always_comb begin
    muldiv_stall = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE:   muldiv_stall = accept;
      ST_BUSY:   muldiv_stall = 1'b1;
      ST_DONE:   result_valid = ~flush;
      ST_CANCEL: muldiv_stall = accept;
      default:   muldiv_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_MULT;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      wd_cnt    <= '0;
      timeout   <= 1'b0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;

      // Watchdog saturates at MAX_LAT while a unit is outstanding.
      if (in_flight && (wd_cnt != CNT_MAX)) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op_e'(req_op);
            op_a <= src_a;
            op_b <= src_b;
            if (div0_fast) begin
              result <= {src_a, DIV0_LO};
              state  <= ST_DONE;
            end else begin
              wd_cnt    <= '0;
              mul_start <= ~req_op[1];
              div_start <= req_op[1];
              state     <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          // A ready coinciding with flush still frees the unit, but the value is dropped.
          if (sel_ready) begin
            if (!flush) begin
              result <= sel_result;
              state  <= ST_DONE;
            end else begin
              state <= ST_IDLE;
            end
          end else if (wd_expire) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else if (flush) begin
            state <= ST_CANCEL;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        ST_CANCEL: begin
          if (sel_ready) begin
            state <= ST_IDLE;
          end else if (wd_expire) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl.  The bench
// plays both arithmetic units, answering with hand-computed results.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        muldiv_stall;
  logic        result_valid;
  logic [63:0] result;
  logic        timeout;
  logic        mul_start;
  logic        mul_sign;
  logic        div_start;
  logic        div_sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_ready;
  logic        div_ready;
  logic [63:0] mul_result;
  logic [63:0] div_result;

  int checks = 0;
  int errors = 0;
  int mul_starts;
  int div_starts;
  logic exp_stall;

  muldiv_ctrl #(.MAX_LAT(40), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .muldiv_stall (muldiv_stall),
    .result_valid (result_valid),
    .result       (result),
    .timeout      (timeout),
    .mul_start    (mul_start),
    .mul_sign     (mul_sign),
    .div_start    (div_start),
    .div_sign     (div_sign),
    .op_a         (op_a),
    .op_b         (op_b),
    .mul_ready    (mul_ready),
    .div_ready    (div_ready),
    .mul_result   (mul_result),
    .div_result   (div_result)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL global_time_limit reached");
    $fatal(1, "[TB] simulation time limit");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive the E-stage request inputs.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = v;
    req_op    = op;
    src_a     = a;
    src_b     = b;
  endtask

  // Move to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    mul_ready  = 1'b0;
    div_ready  = 1'b0;
    mul_result = '0;
    div_result = '0;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);

    // Reset state.
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_stall", 64'(muldiv_stall), 64'd0);
    checkOutput("rst_result_valid", 64'(result_valid), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_timeout", 64'(timeout), 64'd0);
    checkOutput("rst_starts", 64'({mul_start, div_start}), 64'd0);
    nextCycle();
    rst = 1'b0;

    // MULT 0xFFFFFFFE * 3, ready 5 cycles after start.
    $display("[TB] MULT signed");
    applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    checkOutput("mult_issue_stall", 64'(muldiv_stall), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    mul_starts = 0;
    for (int i = 0; i <= 5; i++) begin
      if (i == 5) begin
        mul_ready  = 1'b1;
        mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
      end
      @(negedge clk);
      mul_starts += int'(mul_start);
      checkOutput("mult_busy_stall", 64'(muldiv_stall), 64'd1);
      checkOutput("mult_busy_valid", 64'(result_valid), 64'd0);
      if (i == 0) begin
        checkOutput("mult_sign", 64'(mul_sign), 64'd1);
        checkOutput("mult_op_a", 64'(op_a), 64'hFFFF_FFFE);
        checkOutput("mult_op_b", 64'(op_b), 64'd3);
      end
      nextCycle();
    end
    mul_ready = 1'b0;
    checkOutput("mult_start_count", 64'(mul_starts), 64'd1);
    @(negedge clk);
    checkOutput("mult_done_valid", 64'(result_valid), 64'd1);
    checkOutput("mult_done_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    checkOutput("mult_done_stall", 64'(muldiv_stall), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("mult_after_valid", 64'(result_valid), 64'd0);
    checkOutput("mult_after_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    nextCycle();

    // DIVU 100 / 7, ready 33 cycles after start; a stray mul_ready is ignored.
    $display("[TB] DIVU");
    applyStimulus(1'b1, 2'b11, 32'd100, 32'd7);
    @(negedge clk);
    checkOutput("divu_issue_stall", 64'(muldiv_stall), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    mul_starts = 0;
    div_starts = 0;
    for (int i = 0; i <= 33; i++) begin
      mul_ready = (i == 5);
      if (i == 33) begin
        div_ready  = 1'b1;
        div_result = {32'd2, 32'd14};
      end
      @(negedge clk);
      mul_starts += int'(mul_start);
      div_starts += int'(div_start);
      checkOutput("divu_busy_stall", 64'(muldiv_stall), 64'd1);
      if (i == 0) checkOutput("divu_sign", 64'(div_sign), 64'd0);
      nextCycle();
    end
    div_ready = 1'b0;
    mul_ready = 1'b0;
    checkOutput("divu_div_starts", 64'(div_starts), 64'd1);
    checkOutput("divu_mul_starts", 64'(mul_starts), 64'd0);
    @(negedge clk);
    checkOutput("divu_done_valid", 64'(result_valid), 64'd1);
    checkOutput("divu_done_result", result, {32'd2, 32'd14});
    checkOutput("divu_done_start", 64'(div_start), 64'd0);
    nextCycle();

    // DIV flushed at start+3, drains until ready at start+10; a MULT waits.
    $display("[TB] DIV cancel and drain");
    applyStimulus(1'b1, 2'b10, 32'd50, 32'd5);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    div_starts = 0;
    mul_starts = 0;
    for (int i = 0; i <= 10; i++) begin
      flush = (i == 3);
      if (i == 5) applyStimulus(1'b1, 2'b00, 32'd6, 32'd7);
      if (i == 10) begin
        div_ready  = 1'b1;
        div_result = 64'h0000_DEAD_0000_BEEF;
      end
      exp_stall = (i != 4);
      @(negedge clk);
      div_starts += int'(div_start);
      mul_starts += int'(mul_start);
      checkOutput("cancel_stall", 64'(muldiv_stall), 64'(exp_stall));
      checkOutput("cancel_valid", 64'(result_valid), 64'd0);
      nextCycle();
    end
    div_ready = 1'b0;
    checkOutput("cancel_div_starts", 64'(div_starts), 64'd1);
    checkOutput("cancel_mul_starts", 64'(mul_starts), 64'd0);
    @(negedge clk);
    checkOutput("drain_issue_stall", 64'(muldiv_stall), 64'd1);
    checkOutput("drain_issue_valid", 64'(result_valid), 64'd0);
    checkOutput("drain_result_kept", result, {32'd2, 32'd14});
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("drain_mul_start", 64'(mul_start), 64'd1);
    nextCycle();
    mul_ready  = 1'b1;
    mul_result = 64'd42;
    nextCycle();
    mul_ready = 1'b0;
    @(negedge clk);
    checkOutput("drain_mult_valid", 64'(result_valid), 64'd1);
    checkOutput("drain_mult_result", result, 64'd42);
    nextCycle();

    // MULTU with ready and flush in the same cycle.
    $display("[TB] ready with flush");
    applyStimulus(1'b1, 2'b01, 32'd5, 32'd5);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("rf_mul_start", 64'(mul_start), 64'd1);
    checkOutput("rf_mul_sign", 64'(mul_sign), 64'd0);
    nextCycle();
    nextCycle();
    mul_ready  = 1'b1;
    flush      = 1'b1;
    mul_result = 64'd25;
    @(negedge clk);
    checkOutput("rf_stall", 64'(muldiv_stall), 64'd1);
    nextCycle();
    mul_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    checkOutput("rf_valid", 64'(result_valid), 64'd0);
    checkOutput("rf_result", result, 64'd42);
    checkOutput("rf_stall_idle", 64'(muldiv_stall), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rf_valid_later", 64'(result_valid), 64'd0);
    nextCycle();

    // MULTU 3*4 then DIV -20/3 requested during DONE.
    $display("[TB] back to back");
    applyStimulus(1'b1, 2'b01, 32'd3, 32'd4);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    nextCycle();
    mul_ready  = 1'b1;
    mul_result = 64'd12;
    nextCycle();
    mul_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFEC, 32'd3);
    @(negedge clk);
    checkOutput("b2b_done_valid", 64'(result_valid), 64'd1);
    checkOutput("b2b_done_result", result, 64'd12);
    checkOutput("b2b_done_stall", 64'(muldiv_stall), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_issue_stall", 64'(muldiv_stall), 64'd1);
    checkOutput("b2b_no_early_start", 64'(div_start), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_div_start", 64'(div_start), 64'd1);
    checkOutput("b2b_div_sign", 64'(div_sign), 64'd1);
    nextCycle();
    div_ready  = 1'b1;
    div_result = 64'hFFFF_FFFE_FFFF_FFFA;
    nextCycle();
    div_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_div_valid", 64'(result_valid), 64'd1);
    checkOutput("b2b_div_result", result, 64'hFFFF_FFFE_FFFF_FFFA);
    nextCycle();

    // DIV with src_b == 0.
    $display("[TB] divide by zero");
    applyStimulus(1'b1, 2'b10, 32'h0000_1234, 32'd0);
    @(negedge clk);
    checkOutput("div0_issue_stall", 64'(muldiv_stall), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
`ifdef MULDIV_DIV0_FAST_EN
    @(negedge clk);
    checkOutput("div0_fast_valid", 64'(result_valid), 64'd1);
    checkOutput("div0_fast_result", result, 64'h0000_1234_FFFF_FFFF);
    checkOutput("div0_fast_no_start", 64'(div_start), 64'd0);
    checkOutput("div0_fast_stall", 64'(muldiv_stall), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 2'b11, 32'h0000_5678, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("div0_flush_valid", 64'(result_valid), 64'd0);
    checkOutput("div0_flush_no_start", 64'(div_start), 64'd0);
    nextCycle();
    flush = 1'b0;
`else
    @(negedge clk);
    checkOutput("div0_start", 64'(div_start), 64'd1);
    checkOutput("div0_stall", 64'(muldiv_stall), 64'd1);
    nextCycle();
    div_ready  = 1'b1;
    div_result = 64'h0000_1234_FFFF_FFFF;
    nextCycle();
    div_ready = 1'b0;
    @(negedge clk);
    checkOutput("div0_valid", 64'(result_valid), 64'd1);
    checkOutput("div0_result", result, 64'h0000_1234_FFFF_FFFF);
    nextCycle();
`endif

    // Unit never answers: timeout after 40 BUSY cycles, sticky until reset.
    $display("[TB] watchdog");
    applyStimulus(1'b1, 2'b00, 32'd1, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("wd_busy_stall", 64'(muldiv_stall), 64'd1);
      checkOutput("wd_busy_timeout", 64'(timeout), 64'd0);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wd_timeout", 64'(timeout), 64'd1);
      checkOutput("wd_stall_dropped", 64'(muldiv_stall), 64'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 2'b00, 32'd9, 32'd9);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("wd_reissue_start", 64'(mul_start), 64'd1);
    checkOutput("wd_timeout_held", 64'(timeout), 64'd1);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_stall", 64'(muldiv_stall), 64'd0);
    checkOutput("midrst_timeout", 64'(timeout), 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_valid", 64'(result_valid), 64'd0);
    checkOutput("midrst_op_a", 64'(op_a), 64'd0);
    checkOutput("midrst_ctrl", 64'({mul_start, mul_sign, div_start, div_sign}), 64'd0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
